// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_pkg: access size codes, controller FSM states and byte-lane mask helper for data_mem_ctrl
package data_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: req/ready memory bus (req, we, size, uns, address, write_data -> read_data, ready, busy, err_misaligned, err_range)
interface data_mem_ctrl_if;
  logic req, we, uns, ready, busy, err_misaligned, err_range;
  logic [1:0] size;
  logic [31:0] address, write_data, read_data;
  modport master(output req, we, size, uns, address, write_data, input read_data, ready, busy, err_misaligned, err_range);
  modport slave(input req, we, size, uns, address, write_data, output read_data, ready, busy, err_misaligned, err_range);
endinterface

// File: rtl/data_mem_ctrl_bank.sv
// dmem_bank: one DEPTH x 8 byte lane, sync write with enable, sync read (clk, we, addr, wd -> rd)
module dmem_bank #(
  parameter int DEPTH = 2048,
  parameter int LANE = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wd,
  output logic [7:0]               rd
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= mem[addr];
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed b/h/w data memory with latency-configurable req/ready handshake and fault flags (clk, rst, bus slave)
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int LATENCY = 1,
  parameter string INIT_FILE = ""
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  if (LATENCY < 1) begin : g_bad_latency
    $error("data_mem_ctrl: LATENCY must be >= 1");
  end
  state_t state;
  logic [CW-1:0] cnt;
  logic l_we, l_uns, l_mis, l_rng, acc, mis, rng;
  logic [1:0] l_size;
  logic [AW+1:0] l_addr;
  logic [31:0] l_wd, wdata, sh, ld;
  logic [3:0] wen;
  logic [3:0][7:0] q;
  logic [AW-1:0] idx;
  always_comb begin
    mis = bus.size == SZ_RSVD || (bus.size == SZ_HALF && bus.address[0]) || (bus.size == SZ_WORD && bus.address[1:0] != 2'b00);
    rng = |bus.address[31:AW+2];
    acc = state == BUSY && cnt == '0;
    idx = state == IDLE ? bus.address[AW+1:2] : l_addr[AW+1:2];
    wen = {4{acc && l_we}} & lane_mask(l_size, l_addr[1:0]);
    wdata = l_size == SZ_BYTE ? {4{l_wd[7:0]}} : l_size == SZ_HALF ? {2{l_wd[15:0]}} : l_wd;
    sh = q >> {l_addr[1:0], 3'b000};
    ld = l_size == SZ_BYTE ? {{24{!l_uns && sh[7]}}, sh[7:0]} : l_size == SZ_HALF ? {{16{!l_uns && sh[15]}}, sh[15:0]} : sh;
  end
  assign bus.busy = state != IDLE;
  for (genvar l = 0; l < 4; l++) begin : g_lane
    dmem_bank #(.DEPTH(DEPTH), .LANE(l), .INIT_FILE(INIT_FILE)) u_bank (
      .clk(clk), .we(wen[l]), .addr(idx), .wd(wdata[8*l+:8]), .rd(q[l])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      l_we <= 1'b0;
      l_uns <= 1'b0;
      l_mis <= 1'b0;
      l_rng <= 1'b0;
      l_size <= SZ_BYTE;
      l_addr <= '0;
      l_wd <= '0;
      bus.read_data <= '0;
      bus.ready <= 1'b0;
      bus.err_misaligned <= 1'b0;
      bus.err_range <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.req) begin
        l_we <= bus.we;
        l_uns <= bus.uns;
        l_size <= bus.size;
        l_addr <= bus.address[AW+1:0];
        l_wd <= bus.write_data;
        l_mis <= mis;
        l_rng <= rng;
        cnt <= CW'(LATENCY - 1);
        state <= mis || rng ? RESP : BUSY;
      end
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      if (acc) begin
        state <= RESP;
        bus.ready <= 1'b1;
        if (!l_we) bus.read_data <= ld;
      end
    end else if (!bus.ready) begin
      bus.ready <= 1'b1;
      bus.err_misaligned <= l_mis;
      bus.err_range <= l_rng;
      bus.read_data <= '0;
    end else begin
      state <= IDLE;
      bus.ready <= 1'b0;
      bus.err_misaligned <= 1'b0;
      bus.err_range <= 1'b0;
    end
endmodule
